// File: rtl/ex_operand_issue.sv
// Execute-stage issue register: decodes a MIPS instruction word, selects the
// ALU operands and control bits, and holds them in one ID/EX slot that
// supports valid/ready backpressure, flush and an illegal-instruction counter.
module ex_operand_issue #(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      instr,
   input  logic [XLEN-1:0]  rs_val,
   input  logic [XLEN-1:0]  rt_val,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  alu_a,
   output logic [XLEN-1:0]  alu_b,
   output logic [3:0]       alu_ctrl,
   output logic [4:0]       dest_reg,
   output logic             reg_write,
   output logic             mem_read,
   output logic             mem_write,
   output logic             branch,
   output logic [XLEN-1:0]  store_data,
   output logic             illegal,
   output logic [CNT_W-1:0] illegal_count
);

   localparam logic [3:0] ALU_ADD = 4'h0;
   localparam logic [3:0] ALU_SUB = 4'h1;
   localparam logic [3:0] ALU_XOR = 4'h2;
   localparam logic [3:0] ALU_OR  = 4'h3;
   localparam logic [3:0] ALU_AND = 4'h4;
   localparam logic [3:0] ALU_NOT = 4'h5;
   localparam logic [3:0] ALU_SLL = 4'h6;
   localparam logic [3:0] ALU_SRL = 4'h7;
   localparam logic [3:0] ALU_SLT = 4'h8;
   localparam logic [3:0] ALU_ILL = 4'hF;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [5:0]      op;
   logic [5:0]      funct;
   logic [4:0]      rt_idx;
   logic [4:0]      rd_idx;
   logic [4:0]      shamt;
   logic [15:0]     imm;
   logic [XLEN-1:0] imm_sext;
   logic [XLEN-1:0] imm_zext;
   logic            unused_rs_field;

   logic [XLEN-1:0] a_d, b_d, st_d;
   logic [3:0]      ctrl_d;
   logic [4:0]      dest_d;
   logic            rw_d, mr_d, mw_d, br_d, ill_d;
   logic            accept;

   assign op              = instr[31:26];
   assign rt_idx          = instr[20:16];
   assign rd_idx          = instr[15:11];
   assign shamt           = instr[10:6];
   assign funct           = instr[5:0];
   assign imm             = instr[15:0];
   assign imm_sext        = {{(XLEN-16){imm[15]}}, imm};
   assign imm_zext        = XLEN'(imm);
   // rs index is consumed by the register file upstream; only its value arrives here
   assign unused_rs_field = ^instr[25:21];

   // Slot accepts when empty or being drained this cycle
   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;

   // Decode instruction word into ALU operands and control bits
   always_comb begin
      ctrl_d = ALU_ILL;
      a_d    = '0;
      b_d    = '0;
      st_d   = '0;
      dest_d = '0;
      rw_d   = 1'b0;
      mr_d   = 1'b0;
      mw_d   = 1'b0;
      br_d   = 1'b0;
      ill_d  = 1'b1;
      unique case (op)
         6'h00: begin
            unique case (funct)
               6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h2A, 6'h27: begin
                  a_d    = rs_val;
                  b_d    = (funct == 6'h27) ? '0 : rt_val;
                  dest_d = rd_idx;
                  rw_d   = 1'b1;
                  ill_d  = 1'b0;
                  unique case (funct)
                     6'h20:   ctrl_d = ALU_ADD;
                     6'h22:   ctrl_d = ALU_SUB;
                     6'h24:   ctrl_d = ALU_AND;
                     6'h25:   ctrl_d = ALU_OR;
                     6'h26:   ctrl_d = ALU_XOR;
                     6'h2A:   ctrl_d = ALU_SLT;
                     default: ctrl_d = ALU_NOT;
                  endcase
               end
               6'h00, 6'h02: begin
                  ctrl_d = (funct == 6'h00) ? ALU_SLL : ALU_SRL;
                  a_d    = rt_val;
                  b_d    = XLEN'(shamt);
                  dest_d = rd_idx;
                  rw_d   = 1'b1;
                  ill_d  = 1'b0;
               end
               default: ;
            endcase
         end
         6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h2B: begin
            a_d    = rs_val;
            dest_d = rt_idx;
            ill_d  = 1'b0;
            rw_d   = 1'b1;
            b_d    = imm_sext;
            ctrl_d = ALU_ADD;
            unique case (op)
               6'h0A: ctrl_d = ALU_SLT;
               6'h0C: begin ctrl_d = ALU_AND; b_d = imm_zext; end
               6'h0D: begin ctrl_d = ALU_OR;  b_d = imm_zext; end
               6'h0E: begin ctrl_d = ALU_XOR; b_d = imm_zext; end
               6'h23: mr_d = 1'b1;
               6'h2B: begin mw_d = 1'b1; rw_d = 1'b0; st_d = rt_val; end
               default: ;
            endcase
         end
         6'h04: begin
            ctrl_d = ALU_SUB;
            a_d    = rs_val;
            b_d    = rt_val;
            dest_d = rt_idx;
            br_d   = 1'b1;
            ill_d  = 1'b0;
         end
         default: ;
      endcase
      // Register 0 is hardwired; never request a write to it
      if (dest_d == 5'd0) rw_d = 1'b0;
   end

   // ID/EX slot: flush beats accept, accept beats drain
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid  <= 1'b0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_ctrl   <= ALU_ADD;
         dest_reg   <= '0;
         reg_write  <= 1'b0;
         mem_read   <= 1'b0;
         mem_write  <= 1'b0;
         branch     <= 1'b0;
         store_data <= '0;
         illegal    <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
         illegal   <= 1'b0;
      end else if (accept) begin
         out_valid  <= 1'b1;
         alu_a      <= a_d;
         alu_b      <= b_d;
         alu_ctrl   <= ctrl_d;
         dest_reg   <= dest_d;
         reg_write  <= rw_d;
         mem_read   <= mr_d;
         mem_write  <= mw_d;
         branch     <= br_d;
         store_data <= st_d;
         illegal    <= ill_d;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Saturating count of accepted, unflushed illegal instructions
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         illegal_count <= '0;
      end else if (accept && !flush && ill_d && (illegal_count != CNT_MAX)) begin
         illegal_count <= illegal_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_ex_operand_issue.sv
// Directed bench for ex_operand_issue with hand-computed expectations.
module tb_ex_operand_issue;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] instr;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [3:0]  alu_ctrl;
   logic [4:0]  dest_reg;
   logic        reg_write;
   logic        mem_read;
   logic        mem_write;
   logic        branch;
   logic [31:0] store_data;
   logic        illegal;
   logic [15:0] illegal_count;

   int checks   = 0;
   int failures = 0;

   ex_operand_issue #(.XLEN(32), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .instr(instr), .rs_val(rs_val), .rt_val(rt_val), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .alu_a(alu_a), .alu_b(alu_b),
      .alu_ctrl(alu_ctrl), .dest_reg(dest_reg), .reg_write(reg_write),
      .mem_read(mem_read), .mem_write(mem_write), .branch(branch),
      .store_data(store_data), .illegal(illegal), .illegal_count(illegal_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh,
                                         input logic [5:0] fn);
      return {6'h00, rs, rt, rd, sh, fn};
   endfunction

   function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   // Advance one edge; outputs are sampled 1 time unit after it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one instruction for a single cycle
   task automatic issue(input logic [31:0] w, input logic [31:0] a, input logic [31:0] b);
      instr    = w;
      rs_val   = a;
      rt_val   = b;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   logic [31:0] ill_w;

   initial begin
      rst = 1'b1; in_valid = 1'b0; instr = '0; rs_val = '0; rt_val = '0;
      flush = 1'b0; out_ready = 1'b0;
      ill_w = itype(6'h3F, 5'd1, 5'd2, 16'h1234);
      step(); step();
      rst = 1'b0;

      // Load a stalled instruction, then reset asynchronously mid-cycle
      issue(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 32'd5, 32'd7);
      check("stall_loaded_valid", 32'(out_valid), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_alu_a", alu_a, 32'd0);
      check("rst_alu_b", alu_b, 32'd0);
      check("rst_ctrl", 32'(alu_ctrl), 32'd0);
      check("rst_dest", 32'(dest_reg), 32'd0);
      check("rst_reg_write", 32'(reg_write), 32'd0);
      check("rst_count", 32'(illegal_count), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      step();
      rst = 1'b0;
      out_ready = 1'b1;

      // add $3,$1,$2
      issue(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 32'd5, 32'd7);
      check("add_valid", 32'(out_valid), 32'd1);
      check("add_ctrl", 32'(alu_ctrl), 32'h0);
      check("add_a", alu_a, 32'd5);
      check("add_b", alu_b, 32'd7);
      check("add_dest", 32'(dest_reg), 32'd3);
      check("add_rw", 32'(reg_write), 32'd1);
      check("add_illegal", 32'(illegal), 32'd0);

      // addi $4,$1,-1
      issue(itype(6'h08, 5'd1, 5'd4, 16'hFFFF), 32'd20, 32'd0);
      check("addi_b", alu_b, 32'hFFFF_FFFF);
      check("addi_ctrl", 32'(alu_ctrl), 32'h0);
      check("addi_dest", 32'(dest_reg), 32'd4);

      // ori $4,$1,0xFFFF
      issue(itype(6'h0D, 5'd1, 5'd4, 16'hFFFF), 32'd20, 32'd0);
      check("ori_b", alu_b, 32'h0000_FFFF);
      check("ori_ctrl", 32'(alu_ctrl), 32'h3);

      // sll $5,$2,4
      issue(rtype(5'd0, 5'd2, 5'd5, 5'd4, 6'h00), 32'd99, 32'd3);
      check("sll_a", alu_a, 32'd3);
      check("sll_b", alu_b, 32'd4);
      check("sll_ctrl", 32'(alu_ctrl), 32'h6);
      check("sll_dest", 32'(dest_reg), 32'd5);

      // not $8,$1 (funct 0x27)
      issue(rtype(5'd1, 5'd2, 5'd8, 5'd0, 6'h27), 32'h1234_5678, 32'd77);
      check("not_ctrl", 32'(alu_ctrl), 32'h5);
      check("not_b", alu_b, 32'd0);

      // Stall: sub held while xor waits upstream
      issue(rtype(5'd1, 5'd2, 5'd6, 5'd0, 6'h22), 32'd10, 32'd3);
      out_ready = 1'b0;
      instr = rtype(5'd1, 5'd2, 5'd7, 5'd0, 6'h26);
      rs_val = 32'hF0; rt_val = 32'hFF; in_valid = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         check("stall_in_ready", 32'(in_ready), 32'd0);
         check("stall_ctrl", 32'(alu_ctrl), 32'h1);
         check("stall_a", alu_a, 32'd10);
         check("stall_valid", 32'(out_valid), 32'd1);
         step();
      end
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      check("release_ctrl", 32'(alu_ctrl), 32'h2);
      check("release_a", alu_a, 32'hF0);
      check("release_b", alu_b, 32'hFF);
      check("release_dest", 32'(dest_reg), 32'd7);
      check("release_valid", 32'(out_valid), 32'd1);
      step();
      check("drain_valid", 32'(out_valid), 32'd0);

      // Ten back-to-back addi
      in_valid = 1'b1; rs_val = 32'd100;
      for (int i = 0; i < 10; i++) begin
         instr = itype(6'h08, 5'd1, 5'(i + 1), 16'(i));
         step();
         check("b2b_valid", 32'(out_valid), 32'd1);
         check("b2b_b", alu_b, 32'(i));
         check("b2b_dest", 32'(dest_reg), 32'(i + 1));
      end
      in_valid = 1'b0;
      step();
      check("b2b_drain", 32'(out_valid), 32'd0);

      // Illegal op 0x3F twice
      issue(ill_w, 32'd1, 32'd2);
      check("ill1_ctrl", 32'(alu_ctrl), 32'hF);
      check("ill1_flag", 32'(illegal), 32'd1);
      check("ill1_rw", 32'(reg_write), 32'd0);
      check("ill1_a", alu_a, 32'd0);
      check("ill1_valid", 32'(out_valid), 32'd1);
      check("ill1_count", 32'(illegal_count), 32'd1);
      issue(ill_w, 32'd1, 32'd2);
      check("ill2_count", 32'(illegal_count), 32'd2);

      // Flush while a slot is held and an illegal instruction is accepted
      issue(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 32'd1, 32'd1);
      instr = ill_w; in_valid = 1'b1; flush = 1'b1;
      step();
      in_valid = 1'b0; flush = 1'b0;
      check("flush_valid", 32'(out_valid), 32'd0);
      check("flush_illegal", 32'(illegal), 32'd0);
      check("flush_count", 32'(illegal_count), 32'd2);

      // lw $0,8($1)
      issue(itype(6'h23, 5'd1, 5'd0, 16'd8), 32'h100, 32'd0);
      check("lw_rw", 32'(reg_write), 32'd0);
      check("lw_mr", 32'(mem_read), 32'd1);
      check("lw_a", alu_a, 32'h100);
      check("lw_b", alu_b, 32'd8);

      // sw $2,4($1)
      issue(itype(6'h2B, 5'd1, 5'd2, 16'd4), 32'h200, 32'hDEAD_BEEF);
      check("sw_store", store_data, 32'hDEAD_BEEF);
      check("sw_mw", 32'(mem_write), 32'd1);
      check("sw_rw", 32'(reg_write), 32'd0);
      check("sw_ctrl", 32'(alu_ctrl), 32'h0);

      // beq $1,$2
      issue(itype(6'h04, 5'd1, 5'd2, 16'd16), 32'd9, 32'd9);
      check("beq_ctrl", 32'(alu_ctrl), 32'h1);
      check("beq_branch", 32'(branch), 32'd1);
      check("beq_b", alu_b, 32'd9);
      check("beq_rw", 32'(reg_write), 32'd0);

      // slti with negative immediate
      issue(itype(6'h0A, 5'd1, 5'd9, 16'h8000), 32'd0, 32'd0);
      check("slti_ctrl", 32'(alu_ctrl), 32'h8);
      check("slti_b", alu_b, 32'hFFFF_8000);

      // Undefined R-type funct
      issue(rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h01), 32'd5, 32'd5);
      check("rill_flag", 32'(illegal), 32'd1);
      check("rill_dest", 32'(dest_reg), 32'd0);
      check("rill_count", 32'(illegal_count), 32'd3);

      // Drive the counter to its ceiling, then past it
      instr = ill_w; in_valid = 1'b1;
      for (int i = 0; i < 65532; i++) @(posedge clk);
      #1;
      check("sat_reach", 32'(illegal_count), 32'h0000_FFFF);
      step(); step();
      in_valid = 1'b0;
      check("sat_hold", 32'(illegal_count), 32'h0000_FFFF);
      check("sat_ctrl", 32'(alu_ctrl), 32'hF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
